track_engine: RTL and testbench

Game-state generator for the segment runner: produces the obstacle field, player position, score and score-display request that the 7-segment display decoder consumes. Scrolls pseudo-random ceiling/floor obstacles one column per game tick, toggles the player between floor and ceiling on button press, detects collisions at the player column and counts survived ticks. Sits between the debounced/synchronized button inputs and the display decoder, in the same clock domain.

---
 rtl/segrun_pkg.sv | 15 +
 rtl/track_engine_if.sv | 24 ++
 rtl/lfsr8.sv | 22 ++
 rtl/track_engine.sv | 130 +++++++++++++
 tb/tb_track_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/segrun_pkg.sv
// Shared types and constants for the segment-runner game logic.
package segrun_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_e;

    localparam int unsigned NUM_COLS   = 6;
    localparam int unsigned PLAYER_COL = 4;
    localparam int unsigned SCORE_W    = 14;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 14'd1;
    endfunction

endpackage

// File: rtl/track_engine_if.sv
// Button inputs and game-state outputs between the engine and its neighbours.
interface track_engine_if;
    import segrun_pkg::*;

    logic                loggedIn;
    logic                startBtn;
    logic                flipBtn;
    logic [NUM_COLS-1:0] ceilingBits;
    logic [NUM_COLS-1:0] floorBits;
    logic                playerPos;
    logic [SCORE_W-1:0]  score;
    logic                showScore;

    modport master (
        input  loggedIn, startBtn, flipBtn,
        output ceilingBits, floorBits, playerPos, score, showScore
    );

    modport slave (
        output loggedIn, startBtn, flipBtn,
        input  ceilingBits, floorBits, playerPos, score, showScore
    );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state
);

    logic [7:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/track_engine.sv
// Segment-runner game state: scrolling obstacle field, player side, collision and score.
module track_engine
    import segrun_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    track_engine_if.master bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [NUM_COLS-1:0] ceil_q, ceil_d, floor_q, floor_d;
    logic                player_q, player_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                show_q, show_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, flip_q;
    logic [7:0]          lfsr_state;
    logic                unused_lfsr;

    logic start_edge, flip_edge, tick, new_c, new_f, hit;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state[7:2];
    assign start_edge  = bus.startBtn & ~start_q;
    assign flip_edge   = bus.flipBtn & ~flip_q;

    always_comb begin
        state_d  = state_q;
        ceil_d   = ceil_q;
        floor_d  = floor_q;
        player_d = player_q;
        score_d  = score_q;
        show_d   = show_q;
        cnt_d    = cnt_q;
        tick     = 1'b0;
        new_c    = 1'b0;
        new_f    = 1'b0;
        hit      = 1'b0;

        if (!bus.loggedIn) begin
            state_d  = IDLE;
            ceil_d   = '0;
            floor_d  = '0;
            player_d = 1'b0;
            show_d   = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state_d  = PLAY;
                        ceil_d   = '0;
                        floor_d  = '0;
                        player_d = 1'b0;
                        score_d  = '0;
                        show_d   = 1'b0;
                        cnt_d    = '0;
                    end
                end
                PLAY: begin
                    // Flip lands before the shift so a same-cycle flip can dodge.
                    player_d = player_q ^ flip_edge;
                    tick     = (cnt_q == CNT_LAST);
                    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
                    if (tick) begin
                        // A column after any obstacle is always empty, keeping a path open.
                        if (!(ceil_q[0] | floor_q[0])) begin
                            new_f = (lfsr_state[1:0] == 2'b01);
                            new_c = (lfsr_state[1:0] == 2'b10);
                        end
                        ceil_d  = {ceil_q[NUM_COLS-2:0], new_c};
                        floor_d = {floor_q[NUM_COLS-2:0], new_f};
                    end
                    hit = player_d ? ceil_d[PLAYER_COL] : floor_d[PLAYER_COL];
                    if (hit) begin
                        state_d = OVER;
                        show_d  = 1'b1;
                    end else if (tick) begin
                        score_d = score_inc(score_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ceil_q   <= '0;
            floor_q  <= '0;
            player_q <= 1'b0;
            score_q  <= '0;
            show_q   <= 1'b0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            flip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ceil_q   <= ceil_d;
            floor_q  <= floor_d;
            player_q <= player_d;
            score_q  <= score_d;
            show_q   <= show_d;
            cnt_q    <= cnt_d;
            start_q  <= bus.startBtn;
            flip_q   <= bus.flipBtn;
        end
    end

    assign bus.ceilingBits = ceil_q;
    assign bus.floorBits   = floor_q;
    assign bus.playerPos   = player_q;
    assign bus.score       = score_q;
    assign bus.showScore   = show_q;

endmodule

// File: tb/tb_track_engine.sv
// Randomized bench for track_engine against a column-queue game model.
module tb_track_engine;
    import segrun_pkg::*;

    localparam int unsigned TDIV = 4;
    localparam logic [7:0]  SEED = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    track_engine_if bus ();

    track_engine #(
        .TICK_DIV  (TDIV),
        .LFSR_SEED (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: game mode 0=idle 1=play 2=over; cols[0] is the leftmost column.
    typedef struct packed {
        logic c;
        logic f;
    } col_t;

    col_t cols[$];
    int   m_mode, m_score, m_cnt, m_lfsr;
    bit   m_player, m_show, m_pstart, m_pflip;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int lfsr_next(int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 'hFF;
    endfunction

    function automatic void clear_cols();
        cols.delete();
        for (int i = 0; i < NUM_COLS; i++) cols.push_back(col_t'(2'b00));
    endfunction

    function automatic int field_bits(bit pick_c);
        int b = 0;
        for (int i = 0; i < NUM_COLS; i++)
            if (pick_c ? cols[i].c : cols[i].f) b |= (1 << (NUM_COLS - 1 - i));
        return b;
    endfunction

    always @(posedge clk) begin
        bit   se, fe, tick, hit;
        col_t nc;
        if (rst) begin
            m_mode = 0; clear_cols(); m_player = 0; m_score = 0; m_show = 0;
            m_cnt = 0; m_lfsr = SEED; m_pstart = 0; m_pflip = 0;
        end else begin
            se = bus.startBtn && !m_pstart;
            fe = bus.flipBtn && !m_pflip;
            m_pstart = bus.startBtn;
            m_pflip  = bus.flipBtn;
            if (!bus.loggedIn) begin
                m_mode = 0; clear_cols(); m_player = 0; m_show = 0; m_cnt = 0;
            end else if (m_mode != 1) begin
                if (se) begin
                    m_mode = 1; clear_cols(); m_player = 0; m_score = 0; m_cnt = 0; m_show = 0;
                end
            end else begin
                if (fe) m_player = !m_player;
                tick  = (m_cnt == TDIV - 1);
                m_cnt = tick ? 0 : m_cnt + 1;
                if (tick) begin
                    nc = col_t'(2'b00);
                    if (!(cols[NUM_COLS-1].c || cols[NUM_COLS-1].f)) begin
                        if ((m_lfsr & 3) == 1) nc.f = 1'b1;
                        if ((m_lfsr & 3) == 2) nc.c = 1'b1;
                    end
                    void'(cols.pop_front());
                    cols.push_back(nc);
                end
                hit = m_player ? cols[NUM_COLS-1-PLAYER_COL].c : cols[NUM_COLS-1-PLAYER_COL].f;
                if (hit) begin
                    m_mode = 2; m_show = 1;
                end else if (tick && m_score < 9999) begin
                    m_score++;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // Per-cycle comparison against the model, plus the obstacle gap property.
    always @(negedge clk) begin
        bit ok;
        if (!rst) begin
            chk("ceilingBits", int'(bus.ceilingBits), field_bits(1'b1));
            chk("floorBits", int'(bus.floorBits), field_bits(1'b0));
            chk("playerPos", int'(bus.playerPos), int'(m_player));
            chk("score", int'(bus.score), m_score);
            chk("showScore", int'(bus.showScore), int'(m_show));
            ok = 1'b1;
            for (int i = 0; i < NUM_COLS; i++) begin
                if (bus.ceilingBits[i] && bus.floorBits[i]) ok = 1'b0;
                if (i < NUM_COLS - 1 && (bus.ceilingBits[i] || bus.floorBits[i])
                    && (bus.ceilingBits[i+1] || bus.floorBits[i+1])) ok = 1'b0;
            end
            chk("gap_rule", int'(ok), 1);
        end
    end

    initial begin
        int  cyc;
        bit  need;
        bus.loggedIn = 1'b0;
        bus.startBtn = 1'b0;
        bus.flipBtn  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle hold, and a start press while logged out is ignored.
        repeat (100) @(negedge clk);
        chk("idle_score", int'(bus.score), 0);
        chk("idle_fields", int'({bus.ceilingBits, bus.floorBits}), 0);
        chk("idle_show", int'(bus.showScore), 0);
        bus.startBtn = 1'b1;
        @(negedge clk);
        bus.startBtn = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_login_score", int'(bus.score), 0);

        // Start a game: one tick every TDIV cycles after entry.
        bus.loggedIn = 1'b1;
        @(negedge clk);
        bus.startBtn = 1'b1;
        @(negedge clk);
        bus.startBtn = 1'b0;
        chk("entry_fields", int'({bus.ceilingBits, bus.floorBits}), 0);
        repeat (3) @(negedge clk);
        chk("pre_tick1_score", int'(bus.score), 0);
        @(negedge clk);
        chk("tick1_score", int'(bus.score), 1);
        repeat (4) @(negedge clk);
        chk("tick2_score", int'(bus.score), 2);
        repeat (4) @(negedge clk);
        chk("tick3_score", int'(bus.score), 3);

        // Never flipping: the first floor obstacle at the player column ends the game.
        cyc = 12;
        for (int i = 0; i < 4000 && !bus.showScore; i++) begin
            @(negedge clk);
            cyc++;
        end
        chk("collision_seen", int'(bus.showScore), 1);
        chk("collision_on_tick", cyc % TDIV, 0);
        chk("collision_score", int'(bus.score), cyc / TDIV - 1);
        chk("collision_floor4", int'(bus.floorBits[PLAYER_COL]), 1);
        repeat (9) @(negedge clk);
        chk("over_frozen_score", int'(bus.score), cyc / TDIV - 1);

        // Restart from OVER.
        bus.startBtn = 1'b1;
        @(negedge clk);
        bus.startBtn = 1'b0;
        chk("restart_score", int'(bus.score), 0);
        chk("restart_fields", int'({bus.ceilingBits, bus.floorBits}), 0);
        chk("restart_show", int'(bus.showScore), 0);

        // Perfect dodging: flip on the tick cycle whenever the incoming column blocks us.
        for (int i = 0; i < 10010 * TDIV; i++) begin
            need = (m_mode == 1) && (m_cnt == TDIV - 1) &&
                   ((!m_player && cols[2].f) || (m_player && cols[2].c));
            bus.flipBtn = need;
            @(negedge clk);
        end
        bus.flipBtn = 1'b0;
        chk("saturated_score", int'(bus.score), 9999);
        chk("saturated_show", int'(bus.showScore), 0);

        // Log out mid-game: fields cleared, score held.
        bus.loggedIn = 1'b0;
        @(negedge clk);
        chk("logout_score", int'(bus.score), 9999);
        chk("logout_fields", int'({bus.ceilingBits, bus.floorBits}), 0);
        chk("logout_player", int'(bus.playerPos), 0);
        chk("logout_show", int'(bus.showScore), 0);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            bus.loggedIn = ($urandom_range(63) != 0);
            bus.startBtn = ($urandom_range(31) == 0);
            bus.flipBtn  = ($urandom_range(2) == 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
